// File: rtl/fetch_utlb_stage_if.sv
// ============================================================================
// Module   : fetch_utlb_stage_if
// Brief    : Instruction-bus request channel between the fetch stage and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_utlb_stage_if;
    logic        inst_req;
    logic        inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;

    modport master (
        output inst_req,
        output inst_cache,
        output inst_addr,
        input  inst_addr_ok
    );

    modport slave (
        input  inst_req,
        input  inst_cache,
        input  inst_addr,
        output inst_addr_ok
    );
endinterface

`default_nettype wire

// File: rtl/fetch_utlb_stage.sv
// ============================================================================
// Module   : fetch_utlb_stage
// Brief    : Fetch request stage with a fully associative micro-TLB in front of
//            the shared TLB, plus kseg0/1 bypass and fetch exception detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_utlb_stage #(
    parameter int UTLB_ENTRIES = 4,
    parameter bit PERFCNT_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    fetch_utlb_stage_if.master  ibus,
    input  logic                tlb_write,
    output logic [31:0]         tlb_vaddr,
    input  logic [31:0]         tlb_paddr,
    input  logic                tlb_miss,
    input  logic                tlb_invalid,
    input  logic [2:0]          tlb_cattr,
    input  logic [2:0]          config_k0,
    input  logic                valid_i,
    input  logic [31:0]         pc_i,
    input  logic                ready_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [31:0]         pc_o,
    output logic                cancelled_o,
    output logic                exc_o,
    output logic                exc_miss_o,
    output logic [4:0]          exccode_o,
    input  logic                commit_i,
    output logic [31:0]         perfcnt_fetch_waitreq,
    output logic [31:0]         perfcnt_utlb_miss
);

    localparam int              IDX_W  = (UTLB_ENTRIES > 1) ? $clog2(UTLB_ENTRIES) : 1;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(UTLB_ENTRIES - 1);
    localparam logic [4:0]      C_EXC_ADEL = 5'd4;
    localparam logic [4:0]      C_EXC_TLBL = 5'd2;

    typedef enum logic [1:0] {
        S_CHECK = 2'd0,
        S_QUERY = 2'd1,
        S_REQ   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]             pc_save_q;
    logic [IDX_W-1:0]        rptr_q;
    logic [UTLB_ENTRIES-1:0] valid_q;
    logic [UTLB_ENTRIES-1:0] miss_q;
    logic [UTLB_ENTRIES-1:0] inv_q;
    logic [19:0]             vpn_q   [UTLB_ENTRIES];
    logic [19:0]             pfn_q   [UTLB_ENTRIES];
    logic [2:0]              cattr_q [UTLB_ENTRIES];

    logic kseg01, kseg0, adel, adel_path, flush;
    assign kseg01    = (pc_i[31:30] == 2'b10);
    assign kseg0     = (pc_i[31:29] == 3'b100);
    assign adel      = (pc_i[1:0] != 2'b00);
    assign adel_path = (state_q == S_CHECK) && adel;
    assign flush     = tlb_write || commit_i;
    assign tlb_vaddr = pc_save_q;

    // Associative lookup; entries never share a vpn, so an OR-mux is one-hot.
    logic [UTLB_ENTRIES-1:0] hit_vec;
    logic                    utlb_hit, hit_miss, hit_inv;
    logic [19:0]             hit_pfn;
    logic [2:0]              hit_cattr;

    always_comb begin
        hit_vec   = '0;
        hit_pfn   = '0;
        hit_cattr = '0;
        hit_miss  = 1'b0;
        hit_inv   = 1'b0;
        for (int i = 0; i < UTLB_ENTRIES; i++) begin
            hit_vec[i] = valid_q[i] && (vpn_q[i] == pc_i[31:12]);
            if (hit_vec[i]) begin
                hit_pfn   = hit_pfn   | pfn_q[i];
                hit_cattr = hit_cattr | cattr_q[i];
                hit_miss  = hit_miss  | miss_q[i];
                hit_inv   = hit_inv   | inv_q[i];
            end
        end
    end
    assign utlb_hit = |hit_vec;

    // The entry filled during QUERY sits one slot behind the fill pointer.
    logic [IDX_W-1:0] fill_idx, rptr_next;
    assign fill_idx  = (rptr_q == '0) ? C_LAST : rptr_q - 1'b1;
    assign rptr_next = (rptr_q == C_LAST) ? '0 : rptr_q + 1'b1;

    logic [19:0] fill_pfn;
    logic [2:0]  fill_cattr;
    logic        fill_miss, fill_inv;
    assign fill_pfn   = pfn_q[fill_idx];
    assign fill_cattr = cattr_q[fill_idx];
    assign fill_miss  = miss_q[fill_idx];
    assign fill_inv   = inv_q[fill_idx];

    logic        req_exc, req, cache, ent_miss;
    logic [31:0] addr;

    always_comb begin
        state_d  = state_q;
        req_exc  = 1'b0;
        req      = 1'b0;
        addr     = {hit_pfn, pc_i[11:0]};
        cache    = hit_cattr[0];
        ent_miss = hit_miss;

        case (state_q)
            S_CHECK: begin
                req_exc = valid_i && (adel || (!kseg01 && utlb_hit && (hit_miss || hit_inv)));
                if (kseg01) begin
                    addr  = {3'b000, pc_i[28:0]};
                    cache = kseg0 && config_k0[0];
                end
                req = valid_i && ready_i && !req_exc && (kseg01 || utlb_hit);
                if (valid_i && ready_i && !kseg01 && !utlb_hit && !adel)
                    state_d = S_QUERY;
            end
            S_QUERY: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                req_exc  = fill_miss || fill_inv;
                addr     = {fill_pfn, pc_save_q[11:0]};
                cache    = fill_cattr[0];
                ent_miss = fill_miss;
                req      = valid_i && ready_i && !req_exc;
                if (ready_i && (ibus.inst_addr_ok || req_exc))
                    state_d = S_CHECK;
            end
            default: begin
                state_d = S_CHECK;
            end
        endcase

        if (commit_i)
            state_d = S_CHECK;
    end

    assign ibus.inst_req   = req;
    assign ibus.inst_addr  = addr;
    assign ibus.inst_cache = cache;
    assign ready_o         = ready_i && (ibus.inst_addr_ok || req_exc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CHECK;
            pc_save_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_CHECK)
                pc_save_q <= pc_i;
        end
    end

    // A flush in the fill cycle suppresses the fill and leaves the pointer alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            miss_q  <= '0;
            inv_q   <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < UTLB_ENTRIES; i++) begin
                vpn_q[i]   <= '0;
                pfn_q[i]   <= '0;
                cattr_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (state_q == S_QUERY) begin
            valid_q[rptr_q] <= 1'b1;
            vpn_q[rptr_q]   <= pc_save_q[31:12];
            pfn_q[rptr_q]   <= tlb_paddr[31:12];
            miss_q[rptr_q]  <= tlb_miss;
            inv_q[rptr_q]   <= tlb_invalid;
            cattr_q[rptr_q] <= tlb_cattr;
            rptr_q          <= rptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o     <= 1'b0;
            pc_o        <= '0;
            cancelled_o <= 1'b0;
            exc_o       <= 1'b0;
            exc_miss_o  <= 1'b0;
            exccode_o   <= '0;
        end else if (ready_i) begin
            valid_o     <= (valid_i && ibus.inst_addr_ok) || req_exc;
            pc_o        <= (state_q == S_CHECK) ? pc_i : pc_save_q;
            cancelled_o <= commit_i;
            exc_o       <= req_exc;
            exc_miss_o  <= req_exc && !adel_path && ent_miss;
            exccode_o   <= adel ? C_EXC_ADEL : C_EXC_TLBL;
        end
    end

    generate
        if (PERFCNT_EN) begin : g_perf
            logic [31:0] waitreq_q, utlb_miss_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    waitreq_q   <= '0;
                    utlb_miss_q <= '0;
                end else begin
                    if (req && !ibus.inst_addr_ok)
                        waitreq_q <= waitreq_q + 32'd1;
                    if ((state_q == S_CHECK) && (state_d == S_QUERY))
                        utlb_miss_q <= utlb_miss_q + 32'd1;
                end
            end
            assign perfcnt_fetch_waitreq = waitreq_q;
            assign perfcnt_utlb_miss     = utlb_miss_q;
        end else begin : g_noperf
            assign perfcnt_fetch_waitreq = '0;
            assign perfcnt_utlb_miss     = '0;
        end
    endgenerate

    logic w_unused;
    assign w_unused = ^{config_k0[2:1], tlb_paddr[11:0]};

endmodule

`default_nettype wire

// File: tb/tb_fetch_utlb_stage.sv
// ============================================================================
// Module   : tb_fetch_utlb_stage
// Brief    : Directed self-checking bench for fetch_utlb_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_utlb_stage;

    logic        clk = 1'b0;
    logic        reset, tlb_write, tlb_miss, tlb_invalid;
    logic [31:0] tlb_paddr, pc_i;
    logic [2:0]  tlb_cattr, config_k0;
    logic        valid_i, ready_i, commit_i, ok_en;
    logic [31:0] tlb_vaddr, pc_o, perf_wait, perf_miss;
    logic        ready_o, valid_o, cancelled_o, exc_o, exc_miss_o;
    logic [4:0]  exccode_o;
    int          checks = 0;
    int          failures = 0;
    int          m0, w0;

    fetch_utlb_stage_if bus ();
    // Bus model: accepts a request in the cycle it is raised when ok_en is set.
    assign bus.inst_addr_ok = ok_en & bus.inst_req;

    fetch_utlb_stage #(.UTLB_ENTRIES(4), .PERFCNT_EN(1'b1)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ibus                  (bus),
        .tlb_write             (tlb_write),
        .tlb_vaddr             (tlb_vaddr),
        .tlb_paddr             (tlb_paddr),
        .tlb_miss              (tlb_miss),
        .tlb_invalid           (tlb_invalid),
        .tlb_cattr             (tlb_cattr),
        .config_k0             (config_k0),
        .valid_i               (valid_i),
        .pc_i                  (pc_i),
        .ready_i               (ready_i),
        .ready_o               (ready_o),
        .valid_o               (valid_o),
        .pc_o                  (pc_o),
        .cancelled_o           (cancelled_o),
        .exc_o                 (exc_o),
        .exc_miss_o            (exc_miss_o),
        .exccode_o             (exccode_o),
        .commit_i              (commit_i),
        .perfcnt_fetch_waitreq (perf_wait),
        .perfcnt_utlb_miss     (perf_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; valid_i = 1'b0; commit_i = 1'b0; tlb_write = 1'b0;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full miss sequence: CHECK, QUERY, REQ (bus accepts at once).
    task automatic do_miss(input logic [31:0] pc, input logic [31:0] pa,
                           input logic m, input logic inv, input logic [2:0] ca);
        @(negedge clk);
        valid_i = 1'b1; pc_i = pc; tlb_paddr = pa;
        tlb_miss = m; tlb_invalid = inv; tlb_cattr = ca;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; tlb_write = 1'b0; tlb_paddr = '0; tlb_miss = 1'b0;
        tlb_invalid = 1'b0; tlb_cattr = '0; config_k0 = 3'b011; valid_i = 1'b0;
        pc_i = '0; ready_i = 1'b1; commit_i = 1'b0; ok_en = 1'b1;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", valid_o); end
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc_o); end
        checks++; if (exc_o !== 1'b0 || exc_miss_o !== 1'b0 || cancelled_o !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", exc_o, exc_miss_o, cancelled_o); end
        checks++; if (exccode_o !== 5'd0) begin failures++; $display("FAIL reset_exccode got=%0h exp=0", exccode_o); end
        checks++; if (perf_wait !== 32'd0 || perf_miss !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0h/%0h exp=0/0", perf_wait, perf_miss); end
        checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", bus.inst_req); end
        checks++; if (dut.rptr_q !== 2'd0) begin failures++; $display("FAIL reset_rptr got=%0h exp=0", dut.rptr_q); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        valid_i = 1'b1; pc_i = 32'hBFC00000;
        #1;
        checks++; if (bus.inst_req !== 1'b1) begin failures++; $display("FAIL kseg1_req got=%0h exp=1", bus.inst_req); end
        checks++; if (bus.inst_addr !== 32'h1FC00000) begin failures++; $display("FAIL kseg1_addr got=%0h exp=1fc00000", bus.inst_addr); end
        checks++; if (bus.inst_cache !== 1'b0) begin failures++; $display("FAIL kseg1_cache got=%0h exp=0", bus.inst_cache); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL kseg1_ready got=%0h exp=1", ready_o); end
        step();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'hBFC00000) begin failures++; $display("FAIL kseg1_out got=%0h/%0h exp=1/bfc00000", valid_o, pc_o); end
        @(negedge clk);
        pc_i = 32'h80001000;
        #1;
        checks++; if (bus.inst_addr !== 32'h00001000 || bus.inst_cache !== 1'b1) begin failures++; $display("FAIL kseg0_k3 got=%0h/%0h exp=1000/1", bus.inst_addr, bus.inst_cache); end
        config_k0 = 3'b010;
        #1;
        checks++; if (bus.inst_cache !== 1'b0) begin failures++; $display("FAIL kseg0_k2 got=%0h exp=0", bus.inst_cache); end
        step();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic test_waitreq();
        @(negedge clk);
        valid_i = 1'b1; pc_i = 32'hA0000100; ok_en = 1'b0; w0 = perf_wait;
        #1;
        checks++; if (bus.inst_req !== 1'b1 || ready_o !== 1'b0) begin failures++; $display("FAIL wait_req got=%0h/%0h exp=1/0", bus.inst_req, ready_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL wait_valid got=%0h exp=0", valid_o); end
        step();
        @(negedge clk);
        ok_en = 1'b1;
        #1;
        checks++; if (perf_wait !== w0 + 2) begin failures++; $display("FAIL wait_perf got=%0d exp=%0d", perf_wait, w0 + 2); end
        step();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'hA0000100) begin failures++; $display("FAIL wait_out got=%0h/%0h exp=1/a0000100", valid_o, pc_o); end
        @(negedge clk);
        ready_i = 1'b0; pc_i = 32'h80000200;
        #1;
        checks++; if (bus.inst_req !== 1'b0 || ready_o !== 1'b0) begin failures++; $display("FAIL notready_req got=%0h/%0h exp=0/0", bus.inst_req, ready_o); end
        step();
        checks++; if (pc_o !== 32'hA0000100) begin failures++; $display("FAIL notready_hold got=%0h exp=a0000100", pc_o); end
        @(negedge clk);
        ready_i = 1'b1; valid_i = 1'b0;
    endtask

    task automatic test_miss_hit();
        @(negedge clk);
        valid_i = 1'b1; pc_i = 32'h00400000; tlb_paddr = 32'h12345000;
        tlb_cattr = 3'd3; tlb_miss = 1'b0; tlb_invalid = 1'b0;
        #1;
        checks++; if (bus.inst_req !== 1'b0 || ready_o !== 1'b0) begin failures++; $display("FAIL miss_c0 got=%0h/%0h exp=0/0", bus.inst_req, ready_o); end
        step();
        @(negedge clk);
        #1;
        checks++; if (tlb_vaddr !== 32'h00400000 || bus.inst_req !== 1'b0) begin failures++; $display("FAIL miss_c1 got=%0h/%0h exp=400000/0", tlb_vaddr, bus.inst_req); end
        step();
        @(negedge clk);
        #1;
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h12345000 || bus.inst_cache !== 1'b1) begin failures++; $display("FAIL miss_c2 got=%0h/%0h/%0h exp=1/12345000/1", bus.inst_req, bus.inst_addr, bus.inst_cache); end
        checks++; if (perf_miss !== 32'd1) begin failures++; $display("FAIL miss_perf got=%0d exp=1", perf_miss); end
        step();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h00400000) begin failures++; $display("FAIL miss_out got=%0h/%0h exp=1/400000", valid_o, pc_o); end
        @(negedge clk);
        pc_i = 32'h00400004;
        #1;
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h12345004) begin failures++; $display("FAIL hit_req got=%0h/%0h exp=1/12345004", bus.inst_req, bus.inst_addr); end
        step();
        checks++; if (pc_o !== 32'h00400004 || perf_miss !== 32'd1) begin failures++; $display("FAIL hit_out got=%0h/%0d exp=400004/1", pc_o, perf_miss); end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int p = 1; p <= 5; p++)
            do_miss(32'(p) << 12, 32'h70000000 | (32'(p) << 12), 1'b0, 1'b0, 3'd0);
        do_miss(32'h00001000, 32'h7FF00000, 1'b0, 1'b0, 3'd0);
        checks++; if (perf_miss !== 32'd6) begin failures++; $display("FAIL wrap_misses got=%0d exp=6", perf_miss); end
        checks++; if (dut.rptr_q !== 2'd2) begin failures++; $display("FAIL wrap_rptr got=%0d exp=2", dut.rptr_q); end
        @(negedge clk);
        pc_i = 32'h00003010;
        #1;
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h70003010) begin failures++; $display("FAIL wrap_hit3 got=%0h/%0h exp=1/70003010", bus.inst_req, bus.inst_addr); end
        step();
        @(negedge clk);
        pc_i = 32'h00001004;
        #1;
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h7FF00004) begin failures++; $display("FAIL wrap_hit1 got=%0h/%0h exp=1/7ff00004", bus.inst_req, bus.inst_addr); end
        step();
        @(negedge clk);
        pc_i = 32'h00002000; tlb_paddr = 32'h70002000;
        #1;
        checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL wrap_evict2 got=%0h exp=0", bus.inst_req); end
        step();
        step();
        step();
        checks++; if (perf_miss !== 32'd7) begin failures++; $display("FAIL wrap_miss7 got=%0d exp=7", perf_miss); end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic test_cached_miss();
        m0 = perf_miss;
        @(negedge clk);
        valid_i = 1'b1; pc_i = 32'h00800000; tlb_miss = 1'b1; tlb_invalid = 1'b0;
        step();
        step();
        @(negedge clk);
        #1;
        checks++; if (bus.inst_req !== 1'b0 || ready_o !== 1'b1) begin failures++; $display("FAIL tlbmiss_req got=%0h/%0h exp=0/1", bus.inst_req, ready_o); end
        step();
        checks++; if (exc_o !== 1'b1 || exc_miss_o !== 1'b1 || exccode_o !== 5'd2) begin failures++; $display("FAIL tlbmiss_exc got=%0h/%0h/%0h exp=1/1/2", exc_o, exc_miss_o, exccode_o); end
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h00800000) begin failures++; $display("FAIL tlbmiss_out got=%0h/%0h exp=1/800000", valid_o, pc_o); end
        @(negedge clk);
        tlb_miss = 1'b0;
        #1;
        checks++; if (bus.inst_req !== 1'b0 || ready_o !== 1'b1) begin failures++; $display("FAIL cached_req got=%0h/%0h exp=0/1", bus.inst_req, ready_o); end
        step();
        checks++; if (exc_o !== 1'b1 || exc_miss_o !== 1'b1 || exccode_o !== 5'd2) begin failures++; $display("FAIL cached_exc got=%0h/%0h/%0h exp=1/1/2", exc_o, exc_miss_o, exccode_o); end
        checks++; if (perf_miss !== m0 + 1) begin failures++; $display("FAIL cached_noquery got=%0d exp=%0d", perf_miss, m0 + 1); end
        do_miss(32'h00900000, 32'h0, 1'b0, 1'b1, 3'd0);
        checks++; if (exc_o !== 1'b1 || exc_miss_o !== 1'b0 || exccode_o !== 5'd2) begin failures++; $display("FAIL invalid_exc got=%0h/%0h/%0h exp=1/0/2", exc_o, exc_miss_o, exccode_o); end
        @(negedge clk);
        valid_i = 1'b0; tlb_invalid = 1'b0;
    endtask

    task automatic test_adel();
        m0 = perf_miss;
        @(negedge clk);
        valid_i = 1'b1; pc_i = 32'h00400002;
        #1;
        checks++; if (bus.inst_req !== 1'b0 || ready_o !== 1'b1) begin failures++; $display("FAIL adel_req got=%0h/%0h exp=0/1", bus.inst_req, ready_o); end
        step();
        checks++; if (exc_o !== 1'b1 || exccode_o !== 5'd4 || exc_miss_o !== 1'b0) begin failures++; $display("FAIL adel_exc got=%0h/%0h/%0h exp=1/4/0", exc_o, exccode_o, exc_miss_o); end
        checks++; if (perf_miss !== m0) begin failures++; $display("FAIL adel_noquery got=%0d exp=%0d", perf_miss, m0); end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic test_commit_flush();
        do_miss(32'h00400000, 32'h12345000, 1'b0, 1'b0, 3'd3);
        m0 = perf_miss;
        @(negedge clk);
        pc_i = 32'h00400008;
        #1;
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h12345008) begin failures++; $display("FAIL pre_commit_hit got=%0h/%0h exp=1/12345008", bus.inst_req, bus.inst_addr); end
        step();
        @(negedge clk);
        pc_i = 32'h00600000; tlb_paddr = 32'h66600000;
        step();
        @(negedge clk);
        commit_i = 1'b1;
        step();
        checks++; if (cancelled_o !== 1'b1 || valid_o !== 1'b0 || exc_o !== 1'b0) begin failures++; $display("FAIL commit_out got=%0h/%0h/%0h exp=1/0/0", cancelled_o, valid_o, exc_o); end
        @(negedge clk);
        commit_i = 1'b0; pc_i = 32'h00400000; tlb_paddr = 32'h12345000;
        #1;
        checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL commit_flushed got=%0h exp=0", bus.inst_req); end
        step();
        checks++; if (cancelled_o !== 1'b0) begin failures++; $display("FAIL commit_clear got=%0h exp=0", cancelled_o); end
        checks++; if (perf_miss !== m0 + 2) begin failures++; $display("FAIL commit_requery got=%0d exp=%0d", perf_miss, m0 + 2); end
        step();
        step();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic test_tlb_write();
        @(negedge clk);
        valid_i = 1'b1; pc_i = 32'h00400010;
        #1;
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h12345010) begin failures++; $display("FAIL tlbw_prehit got=%0h/%0h exp=1/12345010", bus.inst_req, bus.inst_addr); end
        step();
        @(negedge clk);
        valid_i = 1'b0; tlb_write = 1'b1;
        step();
        @(negedge clk);
        tlb_write = 1'b0; valid_i = 1'b1; m0 = perf_miss;
        #1;
        checks++; if (bus.inst_req !== 1'b0) begin failures++; $display("FAIL tlbw_flushed got=%0h exp=0", bus.inst_req); end
        step();
        step();
        @(negedge clk);
        #1;
        checks++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h12345010) begin failures++; $display("FAIL tlbw_refill got=%0h/%0h exp=1/12345010", bus.inst_req, bus.inst_addr); end
        step();
        checks++; if (perf_miss !== m0 + 1) begin failures++; $display("FAIL tlbw_perf got=%0d exp=%0d", perf_miss, m0 + 1); end
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_waitreq();
        test_miss_hit();
        test_wrap();
        test_cached_miss();
        test_adel();
        test_commit_flush();
        test_tlb_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
